access_ctrl_param: RTL and testbench

- Parametrised next-generation parking access controller.
- Adds configurable key width and key value, configurable failed-attempt limit, a key-valid strobe, gate-open and key-entry timeouts, and a visible failed-attempt count.
- Sits between the arrival/entry vehicle sensors plus keypad and the gate actuator and alarm outputs. It is the drop-in successor of the fixed-16-bit access controller.

---
 rtl/access_ctrl_param.sv | 152 +++++++++++++++
 tb/tb_access_ctrl_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/access_ctrl_param.sv
// Parametrised parking access controller: keypad-gated entry with wrong-key alarm,
// tailgating lockout, gate-open and key-entry timeouts, and a visible failed-attempt count.
module access_ctrl_param #(
    parameter int unsigned          CLAVE_W        = 16,
    parameter logic [CLAVE_W-1:0]   CLAVE_CORRECTA = 16'h1234,
    parameter int unsigned          MAX_INTENTOS   = 3,
    parameter int unsigned          T_COMPUERTA    = 1000,
    parameter int unsigned          T_CLAVE        = 5000,
    localparam int unsigned         CNT_W          = $clog2(MAX_INTENTOS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sensor_llegada_vehiculo,
    input  logic               sensor_ingreso_vehiculo,
    input  logic               clave_valida,
    input  logic [CLAVE_W-1:0] clave_ingresada,
    output logic               senal_compuerta,
    output logic               senal_alarma_pin,
    output logic               senal_alarma_bloqueo,
    output logic [CNT_W-1:0]   intentos_fallidos
);

    localparam int unsigned T_MAX = (T_CLAVE > T_COMPUERTA) ? T_CLAVE : T_COMPUERTA;
    localparam int unsigned TMR_W = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] T_CLAVE_LAST = TMR_W'(T_CLAVE - 1);
    localparam logic [TMR_W-1:0] T_COMP_LAST  = TMR_W'(T_COMPUERTA - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_INTENTOS);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MAX_INTENTOS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StEsperaClave,
        StAbierta,
        StAlarmaPin,
        StBloqueo
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             compuerta_q, compuerta_d;
    logic             alarma_pin_q, alarma_pin_d;
    logic             alarma_bloqueo_q, alarma_bloqueo_d;

    logic key_match;
    logic key_ok;
    logic key_bad;

    assign key_match = (clave_ingresada == CLAVE_CORRECTA);
    assign key_ok    = clave_valida && key_match;
    assign key_bad   = clave_valida && !key_match;

    // Rule order inside each state is the priority order: keys beat sensors, ingreso beats timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sensor_llegada_vehiculo) begin
                    state_d = StEsperaClave;
                end
            end
            StEsperaClave: begin
                if (key_ok) begin
                    state_d = StAbierta;
                    cnt_d   = '0;
                end else if (key_bad) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = StAlarmaPin;
                        cnt_d   = CNT_MAX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!sensor_llegada_vehiculo) begin
                    state_d = StIdle;
                end else if (timer_q == T_CLAVE_LAST) begin
                    state_d = StIdle;
                end
            end
            StAbierta: begin
                if (sensor_ingreso_vehiculo && sensor_llegada_vehiculo) begin
                    state_d = StBloqueo;
                end else if (sensor_ingreso_vehiculo) begin
                    state_d = StIdle;
                end else if (timer_q == T_COMP_LAST) begin
                    state_d = StIdle;
                end
            end
            StAlarmaPin: begin
                if (key_ok) begin
                    state_d = StAbierta;
                    cnt_d   = '0;
                end
            end
            StBloqueo: begin
                if (key_ok) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Single shared timer: restarts on any state change, runs only in the timed states.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == StEsperaClave || state_q == StAbierta) && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        compuerta_d      = (state_d == StAbierta);
        alarma_pin_d     = (state_d == StAlarmaPin);
        alarma_bloqueo_d = (state_d == StBloqueo);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            timer_q          <= '0;
            cnt_q            <= '0;
            compuerta_q      <= 1'b0;
            alarma_pin_q     <= 1'b0;
            alarma_bloqueo_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            cnt_q            <= cnt_d;
            compuerta_q      <= compuerta_d;
            alarma_pin_q     <= alarma_pin_d;
            alarma_bloqueo_q <= alarma_bloqueo_d;
        end
    end

    assign senal_compuerta      = compuerta_q;
    assign senal_alarma_pin     = alarma_pin_q;
    assign senal_alarma_bloqueo = alarma_bloqueo_q;
    assign intentos_fallidos    = cnt_q;

    a_outputs_exclusive : assert property (@(posedge clock) disable iff (!reset)
        !(senal_alarma_pin && senal_alarma_bloqueo) &&
        !(senal_compuerta && (senal_alarma_pin || senal_alarma_bloqueo)));

endmodule

// File: tb/tb_access_ctrl_param.sv
// Bench for access_ctrl_param: vector table plus hand-written timeout, reset and
// parametrisation sequences, checked through an expected-result queue.
module tb_access_ctrl_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // dut0: default key/width/limit, short timers
    logic        lleg0, ingr0, val0;
    logic [15:0] clave0;
    logic        comp0, pin0, bloq0;
    logic [1:0]  int0;

    // dut1: 24-bit key, single-attempt limit
    logic        lleg1, ingr1, val1;
    logic [23:0] clave1;
    logic        comp1, pin1, bloq1;
    logic [0:0]  int1;

    access_ctrl_param #(
        .CLAVE_W        (16),
        .CLAVE_CORRECTA (16'h1234),
        .MAX_INTENTOS   (3),
        .T_COMPUERTA    (8),
        .T_CLAVE        (10)
    ) dut0 (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (lleg0),
        .sensor_ingreso_vehiculo (ingr0),
        .clave_valida            (val0),
        .clave_ingresada         (clave0),
        .senal_compuerta         (comp0),
        .senal_alarma_pin        (pin0),
        .senal_alarma_bloqueo    (bloq0),
        .intentos_fallidos       (int0)
    );

    access_ctrl_param #(
        .CLAVE_W        (24),
        .CLAVE_CORRECTA (24'hABCDEF),
        .MAX_INTENTOS   (1),
        .T_COMPUERTA    (8),
        .T_CLAVE        (10)
    ) dut1 (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (lleg1),
        .sensor_ingreso_vehiculo (ingr1),
        .clave_valida            (val1),
        .clave_ingresada         (clave1),
        .senal_compuerta         (comp1),
        .senal_alarma_pin        (pin1),
        .senal_alarma_bloqueo    (bloq1),
        .intentos_fallidos       (int1)
    );

    // Expected outputs packed as {compuerta, alarma_pin, alarma_bloqueo, intentos[1:0]}
    typedef struct {
        logic        lleg;
        logic        ingr;
        logic        val;
        logic [15:0] clave;
        logic [4:0]  exp;
        string       name;
    } vec_t;

    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_OPEN = 5'b10000;
    localparam logic [4:0] E_BLQ  = 5'b00100;
    localparam logic [4:0] E_I1   = 5'b00001;
    localparam logic [4:0] E_I2   = 5'b00010;
    localparam logic [4:0] E_PIN3 = 5'b01011;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];

    vec_t tbl[25];

    function automatic vec_t mk(input logic l, input logic i, input logic v,
                                input logic [15:0] k, input logic [4:0] e, input string nm);
        vec_t r;
        r.lleg  = l;
        r.ingr  = i;
        r.val   = v;
        r.clave = k;
        r.exp   = e;
        r.name  = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %b required %b ({compuerta,pin,bloqueo,intentos})",
                     nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of dut0 inputs, queue its expectation, compare after the edge.
    task automatic drive0(input logic l, input logic i, input logic v, input logic [15:0] k,
                          input logic [4:0] e, input string nm);
        logic [4:0] exp;
        string      n;
        lleg0  = l;
        ingr0  = i;
        val0   = v;
        clave0 = k;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        n   = name_q.pop_front();
        chk(n, {comp0, pin0, bloq0, int0}, exp);
    endtask

    task automatic drive1(input logic l, input logic i, input logic v, input logic [23:0] k,
                          input logic [4:0] e, input string nm);
        logic [4:0] exp;
        string      n;
        lleg1  = l;
        ingr1  = i;
        val1   = v;
        clave1 = k;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        exp = exp_q.pop_front();
        n   = name_q.pop_front();
        chk(n, {comp1, pin1, bloq1, 1'b0, int1}, exp);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 16'h0000, E_NONE, "arrive");
        tbl[1]  = mk(1, 0, 1, 16'h1234, E_OPEN, "good_key_open");
        tbl[2]  = mk(0, 1, 0, 16'h0000, E_NONE, "pass_close");
        tbl[3]  = mk(0, 0, 0, 16'h0000, E_NONE, "idle");
        tbl[4]  = mk(1, 0, 0, 16'h0000, E_NONE, "arrive2");
        tbl[5]  = mk(1, 0, 1, 16'h0000, E_I1,   "bad1");
        tbl[6]  = mk(1, 0, 1, 16'h0000, E_I2,   "bad2");
        tbl[7]  = mk(1, 0, 1, 16'h0000, E_PIN3, "bad3_alarm");
        tbl[8]  = mk(0, 0, 1, 16'h0000, E_PIN3, "bad4_saturates");
        tbl[9]  = mk(0, 0, 0, 16'h0000, E_PIN3, "alarm_ignores_leave");
        tbl[10] = mk(0, 0, 1, 16'h1234, E_OPEN, "alarm_recover");
        tbl[11] = mk(1, 1, 0, 16'h0000, E_BLQ,  "tailgate");
        tbl[12] = mk(0, 0, 0, 16'h0000, E_BLQ,  "blq_sensors_low");
        tbl[13] = mk(1, 1, 1, 16'h0000, E_BLQ,  "blq_bad_key");
        tbl[14] = mk(0, 0, 1, 16'h1234, E_NONE, "blq_clear");
        tbl[15] = mk(1, 0, 0, 16'h0000, E_NONE, "arrive3");
        tbl[16] = mk(1, 0, 1, 16'h0000, E_I1,   "persist_bad1");
        tbl[17] = mk(0, 0, 0, 16'h0000, E_I1,   "leave_keeps_count");
        tbl[18] = mk(1, 0, 0, 16'h0000, E_I1,   "arrive4");
        tbl[19] = mk(0, 0, 1, 16'h0000, E_I2,   "bad_key_beats_leave");
        tbl[20] = mk(0, 0, 0, 16'h0000, E_I2,   "leave2");
        tbl[21] = mk(1, 0, 0, 16'h0000, E_I2,   "arrive5");
        tbl[22] = mk(0, 0, 1, 16'h1234, E_OPEN, "good_key_beats_leave");
        tbl[23] = mk(0, 1, 0, 16'h0000, E_NONE, "pass_close2");
        tbl[24] = mk(0, 0, 1, 16'h1234, E_NONE, "idle_ignores_key");

        reset  = 1'b0;
        lleg0  = 1'b0; ingr0 = 1'b0; val0 = 1'b0; clave0 = '0;
        lleg1  = 1'b0; ingr1 = 1'b0; val1 = 1'b0; clave1 = '0;
        #12;
        chk("reset_dut0", {comp0, pin0, bloq0, int0}, E_NONE);
        chk("reset_dut1", {comp1, pin1, bloq1, 1'b0, int1}, E_NONE);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive0(tbl[i].lleg, tbl[i].ingr, tbl[i].val, tbl[i].clave, tbl[i].exp, tbl[i].name);
        end

        // Gate timeout: open for exactly T_COMPUERTA cycles.
        drive0(1, 0, 0, 16'h0000, E_NONE, "gt_arrive");
        drive0(0, 0, 1, 16'h1234, E_OPEN, "gt_open");
        for (int k = 0; k < 7; k++) drive0(0, 0, 0, 16'h0000, E_OPEN, "gt_hold");
        drive0(0, 0, 0, 16'h0000, E_NONE, "gt_close");

        // Tailgate arriving on the very timeout cycle still locks out.
        drive0(1, 0, 0, 16'h0000, E_NONE, "tie_arrive");
        drive0(0, 0, 1, 16'h1234, E_OPEN, "tie_open");
        for (int k = 0; k < 7; k++) drive0(0, 0, 0, 16'h0000, E_OPEN, "tie_hold");
        drive0(1, 1, 0, 16'h0000, E_BLQ,  "tie_ingreso_wins");
        drive0(0, 0, 1, 16'h1234, E_NONE, "tie_clear");

        // Key on the last ESPERA_CLAVE cycle is still accepted.
        drive0(1, 0, 0, 16'h0000, E_NONE, "kt_arrive_a");
        for (int k = 0; k < 9; k++) drive0(1, 0, 0, 16'h0000, E_NONE, "kt_wait_a");
        drive0(1, 0, 1, 16'h1234, E_OPEN, "kt_last_cycle_key");
        drive0(0, 1, 0, 16'h0000, E_NONE, "kt_pass");

        // Key timeout: after T_CLAVE cycles back in IDLE, key ignored, then re-entry.
        drive0(1, 0, 0, 16'h0000, E_NONE, "kt_arrive_b");
        for (int k = 0; k < 10; k++) drive0(1, 0, 0, 16'h0000, E_NONE, "kt_wait_b");
        drive0(1, 0, 1, 16'h1234, E_NONE, "kt_idle_key_ignored");
        drive0(1, 0, 1, 16'h1234, E_OPEN, "kt_reentered_open");

        // Asynchronous reset between clock edges while the gate is open.
        lleg0 = 1'b0;
        val0  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_dut0", {comp0, pin0, bloq0, int0}, E_NONE);
        chk("async_reset_dut1", {comp1, pin1, bloq1, 1'b0, int1}, E_NONE);
        #3;
        reset = 1'b1;
        drive0(0, 0, 0, 16'h0000, E_NONE, "after_reset_idle");

        // Parametrised instance: bit-23-only mismatch alarms on the first attempt.
        drive1(1, 0, 0, 24'h000000, E_NONE, "p_arrive");
        drive1(1, 0, 1, 24'h2BCDEF, 5'b01001, "p_bit23_alarm");
        drive1(1, 0, 1, 24'hABCDEF, E_OPEN,   "p_recover_open");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
